// File: rtl/mips_cpu_pc_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer (master) and instruction memory (slave).
interface mips_cpu_pc_sequencer_if;
  logic        fetch_read;
  logic        fetch_waitrequest;
  logic [31:0] instr_readdata;

  modport master (
    output fetch_read,
    input  fetch_waitrequest,
    input  instr_readdata
  );

  modport slave (
    input  fetch_read,
    output fetch_waitrequest,
    output instr_readdata
  );
endinterface

// File: rtl/mips_cpu_pc_sequencer.sv
// Multi-cycle MIPS PC sequencer: fetch/execute control, branch/jump decode,
// delay-slot tracking, link strobes, halt on jump to HALT_ADDR.
module mips_cpu_pc_sequencer #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  mips_cpu_pc_sequencer_if.master        fetch,
  input  logic [31:0]                    rs_data,
  input  logic [31:0]                    rt_data,
  input  logic                           ext_stall,
  output logic [1:0]                     pc_ctrl,
  output logic                           pc_en,
  output logic                           link_en,
  output logic                           in_delay_slot,
  output logic                           active,
  output logic                           fault
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic        in_ds_reg, in_ds_next;
  logic        halt_pend_reg, halt_pend_next;
  logic        fault_reg, fault_next;

  logic [5:0]  op;
  logic [4:0]  rt_field;
  logic [5:0]  funct;
  logic        is_ctrl, is_link, is_jr;
  logic [1:0]  sel;
  logic        rs_neg, rs_zero;
  logic        fetch_read_c;
  logic        unused_instr_bits;

  assign op       = instr_reg[31:26];
  assign rt_field = instr_reg[20:16];
  assign funct    = instr_reg[5:0];
  assign rs_neg   = rs_data[31];
  assign rs_zero  = (rs_data == 32'd0);
  assign unused_instr_bits = ^{instr_reg[25:21], instr_reg[15:6]};

  // Decode works on the latched instruction and the live register operands.
  always_comb begin
    is_ctrl = 1'b0;
    is_link = 1'b0;
    is_jr   = 1'b0;
    sel     = PC_PLUS4;
    case (op)
      6'd0: begin
        if (funct == 6'd8 || funct == 6'd9) begin
          is_ctrl = 1'b1;
          is_jr   = 1'b1;
          is_link = (funct == 6'd9);
          sel     = PC_REG;
        end
      end
      6'd1: begin
        case (rt_field)
          5'd0:  begin is_ctrl = 1'b1; sel = rs_neg  ? PC_BRANCH : PC_PLUS4; end
          5'd1:  begin is_ctrl = 1'b1; sel = !rs_neg ? PC_BRANCH : PC_PLUS4; end
          5'd16: begin is_ctrl = 1'b1; is_link = 1'b1; sel = rs_neg  ? PC_BRANCH : PC_PLUS4; end
          5'd17: begin is_ctrl = 1'b1; is_link = 1'b1; sel = !rs_neg ? PC_BRANCH : PC_PLUS4; end
          default: ;
        endcase
      end
      6'd2: begin is_ctrl = 1'b1; sel = PC_JUMP; end
      6'd3: begin is_ctrl = 1'b1; is_link = 1'b1; sel = PC_JUMP; end
      6'd4: begin is_ctrl = 1'b1; sel = (rs_data == rt_data) ? PC_BRANCH : PC_PLUS4; end
      6'd5: begin is_ctrl = 1'b1; sel = (rs_data != rt_data) ? PC_BRANCH : PC_PLUS4; end
      6'd6: begin is_ctrl = 1'b1; sel = (rs_neg || rs_zero) ? PC_BRANCH : PC_PLUS4; end
      6'd7: begin is_ctrl = 1'b1; sel = (!rs_neg && !rs_zero) ? PC_BRANCH : PC_PLUS4; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= FETCH;
      instr_reg     <= 32'd0;
      in_ds_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      in_ds_reg     <= in_ds_next;
      halt_pend_reg <= halt_pend_next;
      fault_reg     <= fault_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    instr_next     = instr_reg;
    in_ds_next     = in_ds_reg;
    halt_pend_next = halt_pend_reg;
    fault_next     = fault_reg;
    fetch_read_c   = 1'b0;
    pc_en          = 1'b0;
    pc_ctrl        = PC_PLUS4;
    link_en        = 1'b0;
    case (state_reg)
      FETCH: begin
        fetch_read_c = 1'b1;
        if (!fetch.fetch_waitrequest) begin
          instr_next = fetch.instr_readdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!ext_stall) begin
          pc_en = 1'b1;
          // A control transfer inside a delay slot is neutralised and flagged.
          if (is_ctrl && in_ds_reg) begin
            fault_next = 1'b1;
            in_ds_next = 1'b0;
          end else begin
            pc_ctrl    = sel;
            link_en    = is_link;
            in_ds_next = is_ctrl;
            if (is_jr && rs_data == HALT_ADDR)
              halt_pend_next = 1'b1;
          end
          if (halt_pend_reg) begin
            halt_pend_next = 1'b0;
            state_next     = HALT;
          end else begin
            state_next = FETCH;
          end
        end
      end
      HALT: ;
      default: state_next = FETCH;
    endcase
  end

  // Registers sit in FETCH during reset, so the request is masked by rst.
  assign fetch.fetch_read = fetch_read_c & rst;
  assign in_delay_slot    = in_ds_reg;
  assign fault            = fault_reg;
  assign active           = (state_reg != HALT);

endmodule

// File: doc/mips_cpu_pc_sequencer.md
MIPS_CPU_PC_SEQUENCER -- requirements
Module: mips_cpu_pc_sequencer

Interface
REQ-001 SHALL have parameter HALT_ADDR, default 32'h0000_0000: jump-register target that ends execution.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_read  output  1  instruction fetch request.
REQ-005 SHALL have port fetch_waitrequest  input  1  memory not ready; fetch data invalid while high.
REQ-006 SHALL have port instr_readdata  input  32  fetched instruction; valid when fetch_read=1 and fetch_waitrequest=0.
REQ-007 SHALL have port rs_data  input  32  register-file value of instr[25:21].
REQ-008 SHALL have port rt_data  input  32  register-file value of instr[20:16].
REQ-009 SHALL have port ext_stall  input  1  datapath (data-memory) stall; holds execute.
REQ-010 SHALL have port pc_ctrl  output  2  next-PC select: 0 = +4, 1 = branch offset, 2 = jump immediate, 3 = register.
REQ-011 SHALL have port pc_en  output  1  one-cycle PC-advance strobe; PC registers update only when high.
REQ-012 SHALL have port link_en  output  1  write return address (PC+8) to link register this cycle.
REQ-013 SHALL have port in_delay_slot  output  1  current instruction is a delay-slot instruction.
REQ-014 SHALL have port active  output  1  CPU running.
REQ-015 SHALL have port fault  output  1  sticky: control-transfer instruction found in delay slot.

Function
REQ-016 SHALL implement FSM states FETCH, EXEC, HALT.
REQ-017 FETCH: fetch_read=1; SHALL stay while fetch_waitrequest=1; SHALL latch instr_readdata into an instruction register and go to EXEC when fetch_waitrequest=0.
REQ-018 EXEC: SHALL stay while ext_stall=1 with pc_en=0, link_en=0; when ext_stall=0 SHALL assert pc_en for exactly one cycle, drive pc_ctrl, then go to FETCH (or HALT per REQ-024).
REQ-019 SHALL decode from the latched instruction: BEQ (op 4, rs==rt), BNE (op 5, rs!=rt), BLEZ (op 6, signed rs<=0), BGTZ (op 7, signed rs>0), REGIMM op 1 with rt field 0 BLTZ, 1 BGEZ, 16 BLTZAL, 17 BGEZAL (signed compare of rs to 0).
REQ-020 Taken branch SHALL give pc_ctrl=1; not-taken branch and non-control instructions SHALL give pc_ctrl=0.
REQ-021 J (op 2), JAL (op 3) SHALL give pc_ctrl=2; JR (op 0, funct 8), JALR (op 0, funct 9) SHALL give pc_ctrl=3.
REQ-022 link_en SHALL pulse with pc_en for JAL, JALR, BLTZAL, BGEZAL (AL branches link whether or not taken).
REQ-023 in_delay_slot SHALL be set at the pc_en of any control instruction (taken or not) and cleared at the next pc_en.
REQ-024 JR/JALR with rs_data==HALT_ADDR SHALL set halt-pending; at the pc_en of the following delay-slot instruction, SHALL enter HALT.
REQ-025 HALT: active=0, fetch_read=0, pc_en=0, link_en=0; SHALL remain until reset.
REQ-026 Control instruction executed while in_delay_slot=1: SHALL force pc_ctrl=0, link_en=0, no halt-pending, set fault=1; pc_en still pulses.
REQ-027 pc_ctrl SHALL be 0 in every cycle in which pc_en=0.
REQ-028 Comparisons SHALL use rs_data/rt_data sampled in the pc_en cycle; datapath holds them stable during ext_stall.

Reset
REQ-029 While rst=0: state FETCH, fetch_read=0, pc_en=0, pc_ctrl=0, link_en=0, in_delay_slot=0, halt-pending=0, fault=0, active=1.
REQ-030 First fetch_read=1 SHALL occur in the first clock cycle after rst deasserts.
REQ-031 rst asserted mid-fetch or mid-stall SHALL abandon the operation immediately with no pc_en pulse.

Verification
REQ-032 ADDU stream, waitrequest=0, ext_stall=0 -> pc_en every 2nd cycle, pc_ctrl=0, in_delay_slot=0.
REQ-033 BEQ with rs=rt=32'h5, then delay-slot ADDU -> pc_ctrl=1 on BEQ pc_en; in_delay_slot=1 during ADDU; 0 after.
REQ-034 BGEZAL with rs=32'hFFFF_FFFF -> pc_ctrl=0, link_en=1 with pc_en.
REQ-035 JR with rs=32'h0, then ADDU -> pc_ctrl=3; HALT after ADDU pc_en; active=0, fetch_read=0 thereafter.
REQ-036 fetch_waitrequest high 3 cycles, then ext_stall 2 cycles -> fetch_read held 4 cycles; single pc_en after stall drops.
REQ-037 J followed by BNE (rs!=rt) in delay slot -> BNE gives pc_ctrl=0, fault=1 sticky; rst low clears fault.
